// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman game sequencer.
// Holds the FSM state encoding, the draw-engine selection codes, the ASCII
// constants used by key classification, and the default sizing values.
package hangman_pkg;

    localparam int unsigned WORD_LEN_DEF   = 10;
    localparam int unsigned MAX_MISSES_DEF = 6;
    localparam int unsigned MISS_W_DEF     = 3;
    localparam int unsigned LETTER_COUNT   = 26;

    typedef enum logic [3:0] {
        ST_INIT_DRAW    = 4'd0,
        ST_LOAD_WORD    = 4'd1,
        ST_BOARD_DRAW   = 4'd2,
        ST_GUESS        = 4'd3,
        ST_CHECK        = 4'd4,
        ST_LETTER_DRAW  = 4'd5,
        ST_GALLOWS_DRAW = 4'd6,
        ST_WIN_DRAW     = 4'd7,
        ST_LOSE_DRAW    = 4'd8,
        ST_OVER         = 4'd9
    } state_e;

    localparam logic [2:0] DRAW_INIT    = 3'd0;
    localparam logic [2:0] DRAW_BOARD   = 3'd1;
    localparam logic [2:0] DRAW_LETTERS = 3'd2;
    localparam logic [2:0] DRAW_GALLOWS = 3'd3;
    localparam logic [2:0] DRAW_WIN     = 3'd4;
    localparam logic [2:0] DRAW_LOSE    = 3'd5;

    localparam logic [7:0] ASCII_ENTER = 8'h0A;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_a     = 8'h61;
    localparam logic [7:0] ASCII_z     = 8'h7A;

    // States that own the draw engine and wait for its done pulse.
    function automatic logic is_draw_state(input state_e s);
        return s inside {ST_INIT_DRAW, ST_BOARD_DRAW, ST_LETTER_DRAW,
                         ST_GALLOWS_DRAW, ST_WIN_DRAW, ST_LOSE_DRAW};
    endfunction

    // Draw-engine selection code for a draw state.
    function automatic logic [2:0] draw_code(input state_e s);
        case (s)
            ST_BOARD_DRAW:   return DRAW_BOARD;
            ST_LETTER_DRAW:  return DRAW_LETTERS;
            ST_GALLOWS_DRAW: return DRAW_GALLOWS;
            ST_WIN_DRAW:     return DRAW_WIN;
            ST_LOSE_DRAW:    return DRAW_LOSE;
            default:         return DRAW_INIT;
        endcase
    endfunction

endpackage

// File: rtl/hangman_game_ctrl_ascii_classify.sv
// Combinational key classifier.
// Ports: code_i (ASCII key code) -> is_letter_c_o, is_enter_c_o,
//        upper_c_o (code folded to upper case), index_c_o (0..25 letter index).
module ascii_classify
    import hangman_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       is_letter_c_o,
    output logic       is_enter_c_o,
    output logic [7:0] upper_c_o,
    output logic [4:0] index_c_o
);

    logic is_upper;
    logic is_lower;

    // Lower-case letters fold to upper case by clearing bit 5.
    always_comb begin
        is_upper      = (code_i >= ASCII_A) && (code_i <= ASCII_Z);
        is_lower      = (code_i >= ASCII_a) && (code_i <= ASCII_z);
        is_letter_c_o = is_upper | is_lower;
        is_enter_c_o  = (code_i == ASCII_ENTER);
        upper_c_o     = is_lower ? (code_i & 8'hDF) : code_i;
        index_c_o     = 5'(upper_c_o - ASCII_A);
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: loads the secret word, runs guesses through the
// letter-check datapath, tracks found letters and misses, and schedules the
// shared draw engine with a start/done handshake.
// Inputs : clock, reset (sync, active high), key_valid_i/key_code_i (key strobe),
//          hit_mask_i (per-slot match of guess_letter_o), draw_done_i.
// Outputs: load_en_o/load_slot_o/load_char_o (letter store write),
//          guess_letter_o, draw_start_o/draw_sel_o, word_len_o, found_mask_o,
//          misses_o, game_over_o, win_o. All outputs are registered.
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN   = WORD_LEN_DEF,
    parameter int unsigned MAX_MISSES = MAX_MISSES_DEF,
    parameter int unsigned MISS_W     = MISS_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                key_valid_i,
    input  logic [7:0]          key_code_i,
    input  logic [WORD_LEN-1:0] hit_mask_i,
    input  logic                draw_done_i,
    output logic                load_en_o,
    output logic [3:0]          load_slot_o,
    output logic [7:0]          load_char_o,
    output logic [7:0]          guess_letter_o,
    output logic                draw_start_o,
    output logic [2:0]          draw_sel_o,
    output logic [3:0]          word_len_o,
    output logic [WORD_LEN-1:0] found_mask_o,
    output logic [MISS_W-1:0]   misses_o,
    output logic                game_over_o,
    output logic                win_o
);

    state_e state_q, state_d;

    logic                    wait_q, wait_d;
    logic                    load_en_q, load_en_d;
    logic [3:0]              load_slot_q, load_slot_d;
    logic [7:0]              load_char_q, load_char_d;
    logic [7:0]              guess_q, guess_d;
    logic                    draw_start_q, draw_start_d;
    logic [2:0]              draw_sel_q, draw_sel_d;
    logic [3:0]              word_len_q, word_len_d;
    logic [WORD_LEN-1:0]     found_q, found_d;
    logic [MISS_W-1:0]       misses_q, misses_d;
    logic                    over_q, over_d;
    logic                    win_q, win_d;
    logic [LETTER_COUNT-1:0] used_q, used_d;

    logic                is_letter;
    logic                is_enter;
    logic [7:0]          upper;
    logic [4:0]          letter_idx;
    logic                key_letter;
    logic                key_enter;
    logic                done_ok;
    logic [WORD_LEN-1:0] len_mask;
    logic [WORD_LEN-1:0] hit;

    ascii_classify u_classify (
        .code_i        (key_code_i),
        .is_letter_c_o (is_letter),
        .is_enter_c_o  (is_enter),
        .upper_c_o     (upper),
        .index_c_o     (letter_idx)
    );

    // Keys are dropped while a draw is outstanding; done only counts once issued.
    always_comb begin
        key_letter = key_valid_i && is_letter && !is_draw_state(state_q);
        key_enter  = key_valid_i && is_enter  && !is_draw_state(state_q);
        done_ok    = draw_done_i && wait_q;
        for (int unsigned i = 0; i < WORD_LEN; i++) begin
            len_mask[i] = (i < 32'(word_len_q));
        end
        hit = hit_mask_i & len_mask;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_INIT_DRAW;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_DRAW:  if (done_ok) state_d = ST_LOAD_WORD;
            ST_LOAD_WORD: begin
                if (key_letter && (word_len_q == 4'(WORD_LEN - 1))) state_d = ST_BOARD_DRAW;
                else if (key_enter && (word_len_q != 4'd0))         state_d = ST_BOARD_DRAW;
            end
            ST_BOARD_DRAW: if (done_ok) state_d = ST_GUESS;
            ST_GUESS:      if (key_letter && !used_q[letter_idx]) state_d = ST_CHECK;
            ST_CHECK:      state_d = (hit != '0) ? ST_LETTER_DRAW : ST_GALLOWS_DRAW;
            ST_LETTER_DRAW, ST_GALLOWS_DRAW: begin
                if (done_ok) begin
                    if (found_q == len_mask)                  state_d = ST_WIN_DRAW;
                    else if (misses_q == MISS_W'(MAX_MISSES)) state_d = ST_LOSE_DRAW;
                    else                                      state_d = ST_GUESS;
                end
            end
            ST_WIN_DRAW, ST_LOSE_DRAW: if (done_ok) state_d = ST_OVER;
            ST_OVER:       if (key_enter) state_d = ST_INIT_DRAW;
            default:       state_d = ST_INIT_DRAW;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        wait_d      = is_draw_state(state_d);
        load_en_d   = 1'b0;
        load_slot_d = load_slot_q;
        load_char_d = load_char_q;
        guess_d     = guess_q;
        word_len_d  = word_len_q;
        found_d     = found_q;
        misses_d    = misses_q;
        used_d      = used_q;

        // A draw is requested on the edge that enters a draw state; the first
        // draw after reset is issued once since its entry edge was the reset.
        draw_start_d = is_draw_state(state_d) && ((state_d != state_q) || !wait_q);
        draw_sel_d   = draw_start_d ? draw_code(state_d) : draw_sel_q;
        over_d       = (state_d == ST_OVER);
        win_d        = over_d && (win_q || (state_q == ST_WIN_DRAW));

        case (state_q)
            ST_LOAD_WORD: begin
                if (key_letter) begin
                    load_en_d   = 1'b1;
                    load_slot_d = word_len_q;
                    load_char_d = upper;
                    word_len_d  = word_len_q + 4'd1;
                end
            end
            ST_GUESS: begin
                if (key_letter && !used_q[letter_idx]) begin
                    guess_d            = upper;
                    used_d[letter_idx] = 1'b1;
                end
            end
            ST_CHECK: begin
                if (hit != '0)                          found_d  = found_q | hit;
                else if (misses_q != MISS_W'(MAX_MISSES)) misses_d = misses_q + MISS_W'(1);
            end
            ST_OVER: begin
                if (key_enter) begin
                    word_len_d = '0;
                    found_d    = '0;
                    misses_d   = '0;
                    used_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q       <= 1'b0;
            load_en_q    <= 1'b0;
            load_slot_q  <= '0;
            load_char_q  <= '0;
            guess_q      <= '0;
            draw_start_q <= 1'b0;
            draw_sel_q   <= '0;
            word_len_q   <= '0;
            found_q      <= '0;
            misses_q     <= '0;
            over_q       <= 1'b0;
            win_q        <= 1'b0;
            used_q       <= '0;
        end else begin
            wait_q       <= wait_d;
            load_en_q    <= load_en_d;
            load_slot_q  <= load_slot_d;
            load_char_q  <= load_char_d;
            guess_q      <= guess_d;
            draw_start_q <= draw_start_d;
            draw_sel_q   <= draw_sel_d;
            word_len_q   <= word_len_d;
            found_q      <= found_d;
            misses_q     <= misses_d;
            over_q       <= over_d;
            win_q        <= win_d;
            used_q       <= used_d;
        end
    end

    assign load_en_o      = load_en_q;
    assign load_slot_o    = load_slot_q;
    assign load_char_o    = load_char_q;
    assign guess_letter_o = guess_q;
    assign draw_start_o   = draw_start_q;
    assign draw_sel_o     = draw_sel_q;
    assign word_len_o     = word_len_q;
    assign found_mask_o   = found_q;
    assign misses_o       = misses_q;
    assign game_over_o    = over_q;
    assign win_o          = win_q;

endmodule
